// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/DM single-port memory arbiter.
//   state_e : arbiter FSM states (2-bit)
//   owner_e : which requester currently holds the memory port
package mem_arbiter_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned OWNER_W = 2;
    localparam int unsigned CTR_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [OWNER_W-1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter_timeout_ctr.sv
// WAIT-state cycle counter with expiry detect.
//   clk, rst   : clock, async active-high reset
//   clr        : synchronous clear (has priority over en)
//   en         : count one WAIT cycle
//   expired_c  : high in the WAIT cycle whose increment reaches TIMEOUT
module arb_timeout_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam logic [CTR_W-1:0] LAST = CTR_W'(TIMEOUT - 1);

    logic [CTR_W-1:0] count;

    // Cycle counter, cleared whenever the FSM is outside WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CTR_W'(1);
        end
    end

    // Current cycle is the TIMEOUT-th WAIT cycle
    assign expired_c = en && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and data memory (DM).
//   if_req/if_addr -> if_rdata/if_done/if_stall : fetch requester
//   dm_rd/dm_wr/dm_addr/dm_wdata -> dm_rdata/dm_done/dm_stall : data requester
//   mem_en/mem_wr/mem_addr/mem_wdata, mem_rdata/mem_ready : shared memory
//   err : one-cycle pulse on illegal DM request or memory timeout
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    state_e state;
    owner_e owner;
    logic   wr_q;
    logic   expired_c;

    arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr       (state != ST_WAIT),
        .en        (state == ST_WAIT),
        .expired_c (expired_c)
    );

    // Stalls drop in the same cycle the done pulse is seen
    assign if_stall = if_req & ~if_done;
    assign dm_stall = (dm_rd | dm_wr) & ~dm_done;

    // Arbiter FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            wr_q      <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            if_done <= 1'b0;
            dm_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // DM first: its access belongs to the older instruction
                    if (dm_rd && dm_wr) begin
                        owner   <= OWN_DM;
                        wr_q    <= 1'b0;
                        err     <= 1'b1;
                        dm_done <= 1'b1;
                        state   <= ST_DONE;
                    end else if (dm_rd || dm_wr) begin
                        owner     <= OWN_DM;
                        wr_q      <= dm_wr;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_en    <= 1'b1;
                        mem_wr    <= dm_wr;
                        state     <= ST_ISSUE;
                    end else if (if_req) begin
                        owner     <= OWN_IF;
                        wr_q      <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_en    <= 1'b1;
                        mem_wr    <= 1'b0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_wr <= 1'b0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // mem_ready wins over a coincident timeout
                    if (mem_ready || expired_c) begin
                        err <= ~mem_ready;
                        if (owner == OWN_IF) begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            dm_done <= 1'b1;
                            if (!mem_ready) begin
                                dm_rdata <= '0;
                            end else if (!wr_q) begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    owner <= OWN_NONE;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Single-port memory arbiter between instruction fetch (IF) and the data-memory stage (DM) of the 5-stage pipeline. It drives one shared multi-cycle memory with a ready handshake, and returns data and completion pulses to each requester. It also produces per-requester stall signals, which the hazard/stall logic ORs into PC stall and NOP insertion. It detects illegal requests and memory timeouts.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
TIMEOUT, 15, max cycles in WAIT before error abort (1..15, 4-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held until if_done
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction; valid when if_done=1
if_done  out  1  one-cycle completion pulse for IF
if_stall  out  1  if_req & ~if_done
dm_rd  in  1  data read request; held until dm_done
dm_wr  in  1  data write request; held until dm_done
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_rdata  out  DATA_W  read data; valid when dm_done=1 after a read
dm_done  out  1  one-cycle completion pulse for DM
dm_stall  out  1  (dm_rd|dm_wr) & ~dm_done
mem_en  out  1  one-cycle issue strobe to memory
mem_wr  out  1  write qualifier, valid with mem_en
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, one cycle
err  out  1  one-cycle pulse: illegal request or timeout

Behaviour:
- Reset (async, rst=1): state=IDLE, owner=none, counter=0. All outputs 0, including rdata registers and mem_* registers.
- States:
  - IDLE -> ISSUE on any legal request.
  - ISSUE -> WAIT unconditionally.
  - WAIT -> DONE on mem_ready, or when the counter reaches TIMEOUT.
  - DONE -> IDLE unconditionally.
- IDLE grant: DM has fixed priority over IF, because the data access belongs to the older instruction.
  - On grant, latch owner, addr, wdata and wr into registers.
  - Requests not granted wait; their stall stays high.
- Illegal request: dm_rd & dm_wr both high in IDLE.
  - No memory access is made.
  - Go straight to DONE with owner=DM and err=1; dm_rdata is unchanged.
  - IF is not granted that cycle.
- ISSUE: mem_en=1 and mem_wr=latched wr for exactly this cycle. mem_addr and mem_wdata are held stable from ISSUE through the end of WAIT.
- WAIT:
  - The counter increments each cycle.
  - On mem_ready, capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
  - If the counter reaches TIMEOUT without mem_ready, go to DONE with err=1; the owner's rdata is set to 0.
  - mem_ready and timeout in the same cycle: mem_ready wins, no error.
- DONE:
  - The owner's done pulses for 1 cycle.
  - No grant is made in this cycle, so a still-asserted req cannot double-issue.
  - Then return to IDLE; the counter clears.
- mem_ready outside WAIT is ignored.
- Minimum latency: request seen at T, mem_en at T+1, mem_ready at T+2, done at T+3, next grant possible at T+4.
- The non-owner's rdata holds its last value.
- A requester dropping its request mid-transaction does not abort it; the done pulse still occurs and is ignored.
- A write's dm_done leaves dm_rdata unchanged.
- rst asserted mid-transaction abandons the access immediately: mem_en=0, no done, no err.

Decomposition:
- Shared package: state encoding (IDLE, ISSUE, WAIT, DONE as 2-bit localparams) and owner encoding (NONE, IF, DM).
- One natural sub-module, arb_timeout_ctr: a 4-bit counter with clear, enable and an "expired" output comparing against TIMEOUT.
- All registers use the async-reset flop variant.

Test Plan:
- IF read only:
  - Stimulus: if_req=1, if_addr=0x0010; mem_ready one cycle after mem_en with mem_rdata=0xA5A5.
  - Expect: mem_en at T+1 with mem_addr=0x0010, mem_wr=0; if_done at T+3 with if_rdata=0xA5A5; if_stall high T..T+2.
- Simultaneous requests:
  - Stimulus: if_req and dm_rd (addr 0x0200) asserted at the same time.
  - Expect: DM served first; IF's mem_en no earlier than 4 cycles after DM's; if_stall held throughout.
- DM write:
  - Stimulus: dm_wr=1, addr=0x0040, wdata=0x1234.
  - Expect: mem_en=1, mem_wr=1, mem_wdata=0x1234; dm_done pulse; dm_rdata unchanged.
- Timeout:
  - Stimulus: dm_rd with mem_ready never asserted, TIMEOUT=15.
  - Expect: err and dm_done pulse together after 15 WAIT cycles; dm_rdata=0x0000.
- Illegal request:
  - Stimulus: dm_rd=dm_wr=1.
  - Expect: no mem_en; err and dm_done pulse on the cycle after the request.
- Mid-transaction reset:
  - Stimulus: rst pulsed during WAIT.
  - Expect: all outputs 0 immediately; a late mem_ready is ignored; the next request proceeds normally.
